zap_store_formatter: RTL and testbench
======================================

# zap_store_formatter

Store-side counterpart of the memory stage's load alignment path. It accepts store requests from the ALU/memory pipeline and formats them into data-cache write beats: lane-replicated write data, 4-bit byte enables and a word-aligned address. Formatted beats are held in a small FIFO with a valid/stall handshake toward the data cache, which decouples cache stalls from the issuing stage. It sits between the ALU stage store outputs and the data cache write port.

## Interface
- DEPTH, 2, FIFO entries; power of two, >= 2.
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_clear  in  1  flush from writeback; synchronous, drops all entries.
- i_req_valid  in  1  store request present.
- o_req_ready  out  1  FIFO can accept; a request is taken when i_req_valid && o_req_ready.
- i_addr  in  32  byte address of store.
- i_data  in  32  store source data, right-justified.
- i_byte  in  1  byte store.
- i_half  in  1  halfword store; i_byte has priority; neither = word.
- i_user  in  1  user-mode access tag, passed through.
- o_wb_valid  out  1  head beat valid.
- i_wb_stall  in  1  cache cannot accept this cycle.
- o_wb_addr  out  32  {addr[31:2], 2'b00}.
- o_wb_data  out  32  lane-replicated data.
- o_wb_be  out  4  byte enables, bit n = byte lane n.
- o_wb_user  out  1  i_user of head beat.
- o_empty  out  1  FIFO empty (for barrier/drain logic).
- o_align_warn  out  1  one-cycle pulse: accepted halfword with addr[0]=1.

## Operation
- Formatting applied at push; FIFO stores {addr, data, be, user}.
- Byte: data = {4{i_data[7:0]}}; be = 4'b0001 << i_addr[1:0].
- Half: data = {2{i_data[15:0]}}; be = i_addr[1] ? 4'b1100 : 4'b0011; i_addr[0] ignored, o_align_warn pulsed (UNPREDICTABLE, not faulted).
- Word: data = i_data unrotated; be = 4'b1111; i_addr[1:0] ignored.
- Occupancy counter width $clog2(DEPTH)+1; rd/wr pointers $clog2(DEPTH) bits, wrap modulo DEPTH.
- Push: i_req_valid && o_req_ready. Pop: o_wb_valid && !i_wb_stall.
- o_req_ready = (count != DEPTH); registered-state function only, no combinational path from i_wb_stall or i_req_valid.
- o_wb_valid = (count != 0); o_empty = (count == 0); o_wb_* driven from head entry storage.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, no push, pop frees slot next cycle.
- Beat presented with o_wb_valid held stable (addr/data/be/user unchanged) until popped.
- Reset: count=0, pointers=0, o_align_warn=0; entry storage not reset (don't-care). Outputs after reset: o_wb_valid=0, o_empty=1, o_req_ready=1, o_align_warn=0, o_wb_addr/data/be/user X-tolerant.
- i_clear: same effect as reset on count/pointers/o_align_warn; push in same cycle is discarded; pending beats lost (cache must not consume after clear). i_reset dominates i_clear.

## Timing
- Latency: request accepted at edge N -> o_wb_valid and formatted beat visible after edge N (cycle N+1) if FIFO was empty.
- Throughput: one beat per cycle sustained when i_wb_stall=0 and DEPTH >= 2.
- o_align_warn asserted the cycle after the accepting edge, for exactly one cycle.
- o_req_ready deasserts the cycle after the push that fills the FIFO; reasserts the cycle after the first pop from full.
- Reset or clear mid-stream: o_wb_valid=0 from the next cycle; no stale beat reappears.

## Test plan
- Byte store addr=0x1003 data=0x000000A5 -> o_wb_addr=0x1000, o_wb_data=0xA5A5A5A5, o_wb_be=4'b1000, valid next cycle.
- Half store addr=0x2002 data=0xFFFF1234 -> data=0x12341234, be=4'b1100; repeat addr=0x2003 -> same beat plus o_align_warn one-cycle pulse.
- Word store addr=0x3001 data=0xDEADBEEF -> addr=0x3000, data=0xDEADBEEF, be=4'b1111.
- Hold i_wb_stall=1, issue 3 back-to-back stores with DEPTH=2 -> o_req_ready=0 after 2 accepted, third held; release stall -> beats drained in order, third accepted, no loss or duplication.
- Continuous requests with i_wb_stall=0 -> one beat per cycle, count stays 1, ordering preserved across pointer wrap (>= 2*DEPTH beats).
- Fill FIFO, assert i_clear together with i_req_valid -> next cycle o_wb_valid=0, o_empty=1, o_req_ready=1; same-cycle request not stored. Repeat with i_reset -> identical result.

Source files
------------

// File: rtl/zap_store_formatter.sv
// zap_store_formatter: formats store requests into lane-replicated data-cache
// write beats (data, byte enables, word address) and buffers them in a small
// FIFO with a valid/stall handshake toward the data cache.
module zap_store_formatter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        i_byte,
    input  logic        i_half,
    input  logic        i_user,
    output logic        o_wb_valid,
    input  logic        i_wb_stall,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_be,
    output logic        o_wb_user,
    output logic        o_empty,
    output logic        o_align_warn
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        user;
    } beat_t;

    beat_t              mem_q [DEPTH];
    beat_t              fmt_d;
    logic               fmt_warn;

    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               align_warn_q, align_warn_d;

    logic               push;
    logic               pop;

    // Handshake status derived only from registered occupancy
    assign o_req_ready = (count_q != CNT_W'(DEPTH));
    assign o_wb_valid  = (count_q != '0);
    assign o_empty     = (count_q == '0);

    assign push = i_req_valid && o_req_ready;
    assign pop  = o_wb_valid && !i_wb_stall;

    // Head entry drives the cache write port
    assign o_wb_addr    = mem_q[rd_ptr_q].addr;
    assign o_wb_data    = mem_q[rd_ptr_q].data;
    assign o_wb_be      = mem_q[rd_ptr_q].be;
    assign o_wb_user    = mem_q[rd_ptr_q].user;
    assign o_align_warn = align_warn_q;

    // Format the incoming request by access size; byte wins over halfword
    always_comb begin
        fmt_d      = '0;
        fmt_warn   = 1'b0;
        fmt_d.addr = {i_addr[31:2], 2'b00};
        fmt_d.user = i_user;
        if (i_byte) begin
            fmt_d.data = {4{i_data[7:0]}};
            fmt_d.be   = 4'b0001 << i_addr[1:0];
        end else if (i_half) begin
            fmt_d.data = {2{i_data[15:0]}};
            fmt_d.be   = i_addr[1] ? 4'b1100 : 4'b0011;
            fmt_warn   = i_addr[0];
        end else begin
            fmt_d.data = i_data;
            fmt_d.be   = 4'b1111;
        end
    end

    // Next-state for occupancy, pointers and misalignment pulse
    always_comb begin
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        align_warn_d = push && fmt_warn;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset and flush both empty the queue
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            align_warn_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            align_warn_q <= align_warn_d;
        end
    end

    // Entry storage is not reset; a push coinciding with reset/flush is dropped
    always_ff @(posedge i_clk) begin
        if (push && !i_reset && !i_clear) begin
            mem_q[wr_ptr_q] <= fmt_d;
        end
    end

endmodule

// File: tb/tb_zap_store_formatter.sv
// Directed bench for zap_store_formatter (DEPTH=2).
module tb_zap_store_formatter;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_byte;
    logic        is_half;
    logic        user;
    logic        wb_valid;
    logic        wb_stall;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_be;
    logic        wb_user;
    logic        empty;
    logic        align_warn;

    int n_vec  = 0;
    int n_miss = 0;

    zap_store_formatter #(.DEPTH(2)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_clear      (clr),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_addr       (addr),
        .i_data       (data),
        .i_byte       (is_byte),
        .i_half       (is_half),
        .i_user       (user),
        .o_wb_valid   (wb_valid),
        .i_wb_stall   (wb_stall),
        .o_wb_addr    (wb_addr),
        .o_wb_data    (wb_data),
        .o_wb_be      (wb_be),
        .o_wb_user    (wb_user),
        .o_empty      (empty),
        .o_align_warn (align_warn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic b, input logic h, input logic u);
        req_valid = v;
        addr      = a;
        data      = d;
        is_byte   = b;
        is_half   = h;
        user      = u;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_vec++; if (wb_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid got %b exp 0", wb_valid); end
        n_vec++; if (empty !== 1'b1) begin n_miss++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        n_vec++; if (align_warn !== 1'b0) begin n_miss++; $display("FAIL reset_warn got %b exp 0", align_warn); end
    endtask

    task automatic test_byte();
        set_req(1'b1, 32'h0000_1003, 32'h0000_00A5, 1'b1, 1'b0, 1'b1);
        step();
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (wb_valid !== 1'b1) begin n_miss++; $display("FAIL byte_valid got %b exp 1", wb_valid); end
        n_vec++; if (wb_addr !== 32'h0000_1000) begin n_miss++; $display("FAIL byte_addr got %h exp 00001000", wb_addr); end
        n_vec++; if (wb_data !== 32'hA5A5_A5A5) begin n_miss++; $display("FAIL byte_data got %h exp a5a5a5a5", wb_data); end
        n_vec++; if (wb_be !== 4'b1000) begin n_miss++; $display("FAIL byte_be got %b exp 1000", wb_be); end
        n_vec++; if (wb_user !== 1'b1) begin n_miss++; $display("FAIL byte_user got %b exp 1", wb_user); end
        n_vec++; if (align_warn !== 1'b0) begin n_miss++; $display("FAIL byte_warn got %b exp 0", align_warn); end
        step();
        n_vec++; if (empty !== 1'b1) begin n_miss++; $display("FAIL byte_drained got %b exp 1", empty); end
        // byte takes priority over halfword, odd address raises no warning
        set_req(1'b1, 32'h0000_0001, 32'h1234_5677, 1'b1, 1'b1, 1'b0);
        step();
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (wb_data !== 32'h7777_7777) begin n_miss++; $display("FAIL byteprio_data got %h exp 77777777", wb_data); end
        n_vec++; if (wb_be !== 4'b0010) begin n_miss++; $display("FAIL byteprio_be got %b exp 0010", wb_be); end
        n_vec++; if (align_warn !== 1'b0) begin n_miss++; $display("FAIL byteprio_warn got %b exp 0", align_warn); end
        n_vec++; if (wb_user !== 1'b0) begin n_miss++; $display("FAIL byteprio_user got %b exp 0", wb_user); end
        step();
    endtask

    task automatic test_half();
        set_req(1'b1, 32'h0000_2002, 32'hFFFF_1234, 1'b0, 1'b1, 1'b0);
        step();
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (wb_addr !== 32'h0000_2000) begin n_miss++; $display("FAIL half_addr got %h exp 00002000", wb_addr); end
        n_vec++; if (wb_data !== 32'h1234_1234) begin n_miss++; $display("FAIL half_data got %h exp 12341234", wb_data); end
        n_vec++; if (wb_be !== 4'b1100) begin n_miss++; $display("FAIL half_be got %b exp 1100", wb_be); end
        n_vec++; if (align_warn !== 1'b0) begin n_miss++; $display("FAIL half_warn got %b exp 0", align_warn); end
        step();
        set_req(1'b1, 32'h0000_2003, 32'hFFFF_1234, 1'b0, 1'b1, 1'b0);
        step();
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (wb_data !== 32'h1234_1234) begin n_miss++; $display("FAIL halfodd_data got %h exp 12341234", wb_data); end
        n_vec++; if (wb_be !== 4'b1100) begin n_miss++; $display("FAIL halfodd_be got %b exp 1100", wb_be); end
        n_vec++; if (align_warn !== 1'b1) begin n_miss++; $display("FAIL halfodd_warn got %b exp 1", align_warn); end
        step();
        n_vec++; if (align_warn !== 1'b0) begin n_miss++; $display("FAIL halfodd_warn_pulse got %b exp 0", align_warn); end
        // low halfword lane
        set_req(1'b1, 32'h0000_2000, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0);
        step();
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (wb_be !== 4'b0011) begin n_miss++; $display("FAIL halflo_be got %b exp 0011", wb_be); end
        n_vec++; if (wb_data !== 32'hBEEF_BEEF) begin n_miss++; $display("FAIL halflo_data got %h exp beefbeef", wb_data); end
        step();
    endtask

    task automatic test_word();
        set_req(1'b1, 32'h0000_3001, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        step();
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (wb_addr !== 32'h0000_3000) begin n_miss++; $display("FAIL word_addr got %h exp 00003000", wb_addr); end
        n_vec++; if (wb_data !== 32'hDEAD_BEEF) begin n_miss++; $display("FAIL word_data got %h exp deadbeef", wb_data); end
        n_vec++; if (wb_be !== 4'b1111) begin n_miss++; $display("FAIL word_be got %b exp 1111", wb_be); end
        n_vec++; if (align_warn !== 1'b0) begin n_miss++; $display("FAIL word_warn got %b exp 0", align_warn); end
        step();
        n_vec++; if (empty !== 1'b1) begin n_miss++; $display("FAIL word_drained got %b exp 1", empty); end
    endtask

    task automatic test_back_to_back();
        wb_stall = 1'b1;
        set_req(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        step();
        set_req(1'b1, 32'h0000_0104, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        step();
        set_req(1'b1, 32'h0000_0108, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL full_ready got %b exp 0", req_ready); end
        n_vec++; if (wb_addr !== 32'h0000_0100) begin n_miss++; $display("FAIL full_head got %h exp 00000100", wb_addr); end
        step();
        n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL held_ready got %b exp 0", req_ready); end
        n_vec++; if (wb_data !== 32'h0000_0001) begin n_miss++; $display("FAIL held_head got %h exp 00000001", wb_data); end
        n_vec++; if (wb_valid !== 1'b1) begin n_miss++; $display("FAIL held_valid got %b exp 1", wb_valid); end
        wb_stall = 1'b0;
        step();
        n_vec++; if (wb_data !== 32'h0000_0002) begin n_miss++; $display("FAIL drain1 got %h exp 00000002", wb_data); end
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL drain1_ready got %b exp 1", req_ready); end
        step();
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (wb_data !== 32'h0000_0003) begin n_miss++; $display("FAIL drain2 got %h exp 00000003", wb_data); end
        n_vec++; if (wb_addr !== 32'h0000_0108) begin n_miss++; $display("FAIL drain2_addr got %h exp 00000108", wb_addr); end
        step();
        n_vec++; if (empty !== 1'b1) begin n_miss++; $display("FAIL drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_stream();
        wb_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 32'h0000_4000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
            step();
            n_vec++; if (wb_data !== 32'hA000_0000 + 32'(i)) begin n_miss++; $display("FAIL stream_data[%0d] got %h exp %h", i, wb_data, 32'hA000_0000 + 32'(i)); end
            n_vec++; if (req_ready !== 1'b1 || wb_valid !== 1'b1) begin n_miss++; $display("FAIL stream_hs[%0d] got rdy=%b vld=%b exp 1/1", i, req_ready, wb_valid); end
        end
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        n_vec++; if (empty !== 1'b1) begin n_miss++; $display("FAIL stream_empty got %b exp 1", empty); end
    endtask

    // Fill, then flush (sel=0: i_clear, sel=1: i_reset) with a request present
    task automatic test_flush(input int sel);
        wb_stall = 1'b1;
        set_req(1'b1, 32'h0000_5000, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
        step();
        // one entry queued: ready is high, so the misaligned half is a real push attempt
        set_req(1'b1, 32'h0000_5001, 32'h0000_2222, 1'b0, 1'b1, 1'b0);
        if (sel == 0) clr = 1'b1; else rst = 1'b1;
        step();
        clr = 1'b0;
        rst = 1'b0;
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (wb_valid !== 1'b0 || empty !== 1'b1 || req_ready !== 1'b1 || align_warn !== 1'b0)
            begin n_miss++; $display("FAIL flush1_%0d got v=%b e=%b r=%b w=%b exp 0/1/1/0", sel, wb_valid, empty, req_ready, align_warn); end
        // full FIFO with a pending request
        set_req(1'b1, 32'h0000_6000, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
        step();
        set_req(1'b1, 32'h0000_6004, 32'h0000_0044, 1'b0, 1'b0, 1'b0);
        step();
        set_req(1'b1, 32'h0000_6008, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
        n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL flush_full_%0d got %b exp 0", sel, req_ready); end
        if (sel == 0) clr = 1'b1; else rst = 1'b1;
        step();
        clr = 1'b0;
        rst = 1'b0;
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (wb_valid !== 1'b0 || empty !== 1'b1 || req_ready !== 1'b1)
            begin n_miss++; $display("FAIL flush2_%0d got v=%b e=%b r=%b exp 0/1/1", sel, wb_valid, empty, req_ready); end
        wb_stall = 1'b0;
        step();
        n_vec++; if (wb_valid !== 1'b0) begin n_miss++; $display("FAIL flush_stale_%0d got %b exp 0", sel, wb_valid); end
        // fresh beat after the flush comes out first and alone
        set_req(1'b1, 32'h0000_7000, 32'h0000_0077, 1'b0, 1'b0, 1'b0);
        step();
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (wb_data !== 32'h0000_0077) begin n_miss++; $display("FAIL flush_fresh_%0d got %h exp 00000077", sel, wb_data); end
        step();
        n_vec++; if (empty !== 1'b1) begin n_miss++; $display("FAIL flush_fresh_empty_%0d got %b exp 1", sel, empty); end
    endtask

    initial begin
        rst      = 1'b1;
        clr      = 1'b0;
        wb_stall = 1'b0;
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_back_to_back();
        test_stream();
        test_flush(0);
        test_flush(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
